// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and alignment constants for the PC fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} fetch_state_t;
  localparam int INSTR_BYTES = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;
endpackage

// File: rtl/pc_fetch_stage_pc_reg.sv
// pc_reg: program counter flop with async reset to RESET_PC and load enable.
module pc_reg #(
  parameter int ADDR_W = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] d_i,
  output logic [ADDR_W-1:0] q_o
);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) q_o <= RESET_PC;
    else if (en_i) q_o <= d_i;
endmodule

// File: rtl/pc_fetch_stage.sv
// pc_fetch_stage: registered PC with req/ack instruction fetch and hold-until-advance.
// Define PC_ALIGN_CHECK_EN to trap misaligned NextPC into a sticky FAULT state.
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int CNT_W = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [ADDR_W-1:0]  NextPC,
  input  logic               Advance,
  output logic [ADDR_W-1:0]  CurrentPC,
  output logic               IMemReq,
  output logic [ADDR_W-1:0]  IMemAddr,
  input  logic               IMemAck,
  input  logic [INSTR_W-1:0] IMemData,
  output logic [INSTR_W-1:0] Instruction,
  output logic               InstrValid,
  output logic [CNT_W-1:0]   FetchCount,
  output logic               Fault
);
  fetch_state_t state_q;
  logic [INSTR_W-1:0] instr_q;
  logic valid_q;
  logic [CNT_W-1:0] cnt_q;
  logic load;
  assign load = state_q == HOLD && Advance;
  pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc_reg (
    .clk_i(CLK),
    .rst_i(Reset),
    .en_i (load),
    .d_i  (NextPC),
    .q_o  (CurrentPC)
  );
  // Request is decoded from state so an async reset withdraws it immediately.
  assign IMemReq = state_q == REQ;
  assign IMemAddr = CurrentPC;
  assign Instruction = instr_q;
  assign InstrValid = valid_q;
  assign FetchCount = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
  logic fault_q;
  assign Fault = fault_q;
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt_q <= '0;
      fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: if (IMemAck) begin
          instr_q <= IMemData;
          valid_q <= 1'b1;
          cnt_q <= cnt_q + 1'b1;
          state_q <= HOLD;
        end
        HOLD: if (Advance) begin
          valid_q <= 1'b0;
          fault_q <= (NextPC[1:0] & ALIGN_MASK) != 2'b00;
          state_q <= (NextPC[1:0] & ALIGN_MASK) != 2'b00 ? FAULT : REQ;
        end
        default: state_q <= FAULT;
      endcase
    end
`else
  assign Fault = 1'b0;
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      state_q <= IDLE;
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;
        REQ: if (IMemAck) begin
          instr_q <= IMemData;
          valid_q <= 1'b1;
          cnt_q <= cnt_q + 1'b1;
          state_q <= HOLD;
        end
        HOLD: if (Advance) begin
          valid_q <= 1'b0;
          state_q <= REQ;
        end
        default: state_q <= IDLE;
      endcase
    end
`endif
endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb_pc_fetch_stage: directed checks of reset, fetch handshake, advance, wrap and async reset.
module tb_pc_fetch_stage;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [63:0] next_pc = '0;
  logic advance = 1'b0;
  logic [63:0] cur_pc, imem_addr;
  logic imem_req, imem_ack = 1'b0;
  logic [31:0] imem_data = '0, instr;
  logic instr_valid, fault;
  logic [3:0] fetch_count;
  logic [3:0] exp_cnt;
  int n_vec = 0;
  int n_err = 0;

  pc_fetch_stage #(.ADDR_W(64), .INSTR_W(32), .RESET_PC(64'h0), .CNT_W(4)) dut (
    .CLK(clk),
    .Reset(rst),
    .NextPC(next_pc),
    .Advance(advance),
    .CurrentPC(cur_pc),
    .IMemReq(imem_req),
    .IMemAddr(imem_addr),
    .IMemAck(imem_ack),
    .IMemData(imem_data),
    .Instruction(instr),
    .InstrValid(instr_valid),
    .FetchCount(fetch_count),
    .Fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [63:0] pc, input logic [31:0] data);
    advance = 1'b1;
    next_pc = pc;
    tick();
    advance = 1'b0;
    imem_ack = 1'b1;
    imem_data = data;
    tick();
    imem_ack = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check("rst_req", 64'(imem_req), 64'h0);
    check("rst_pc", cur_pc, 64'h0);
    check("rst_valid", 64'(instr_valid), 64'h0);
    check("rst_instr", 64'(instr), 64'h0);
    check("rst_cnt", 64'(fetch_count), 64'h0);
    check("rst_fault", 64'(fault), 64'h0);
    tick();
    tick();
    rst = 1'b0;
    check("idle_req", 64'(imem_req), 64'h0);
    tick();
    check("zw_req", 64'(imem_req), 64'h1);
    check("zw_addr", imem_addr, 64'h0);
    imem_ack = 1'b1;
    imem_data = 32'h8B02_0020;
    tick();
    imem_ack = 1'b0;
    check("zw_valid", 64'(instr_valid), 64'h1);
    check("zw_instr", 64'(instr), 64'h8B02_0020);
    check("zw_cnt", 64'(fetch_count), 64'h1);
    check("zw_req_low", 64'(imem_req), 64'h0);
    imem_ack = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    tick();
    imem_ack = 1'b0;
    check("hold_ack_instr", 64'(instr), 64'h8B02_0020);
    check("hold_ack_cnt", 64'(fetch_count), 64'h1);
    check("hold_valid", 64'(instr_valid), 64'h1);
    advance = 1'b1;
    next_pc = 64'h40;
    tick();
    advance = 1'b0;
    check("adv_pc", cur_pc, 64'h40);
    check("adv_valid", 64'(instr_valid), 64'h0);
    check("adv_req", 64'(imem_req), 64'h1);
    check("ws_addr1", imem_addr, 64'h40);
    advance = 1'b1;
    next_pc = 64'h80;
    tick();
    advance = 1'b0;
    check("req_adv_pc", cur_pc, 64'h40);
    check("ws_addr2", imem_addr, 64'h40);
    tick();
    check("ws_addr3", imem_addr, 64'h40);
    check("ws_req3", 64'(imem_req), 64'h1);
    tick();
    check("ws_addr4", imem_addr, 64'h40);
    check("ws_valid4", 64'(instr_valid), 64'h0);
    imem_ack = 1'b1;
    imem_data = 32'h1111_2222;
    tick();
    imem_ack = 1'b0;
    check("ws_valid", 64'(instr_valid), 64'h1);
    check("ws_instr", 64'(instr), 64'h1111_2222);
    check("ws_cnt", 64'(fetch_count), 64'h2);
    exp_cnt = 4'd2;
    for (int i = 0; i < 12; i++) begin
      fetch(64'(i * 4 + 256), 32'(i + 32'h100));
      exp_cnt = exp_cnt + 4'd1;
    end
    check("loop_cnt", 64'(fetch_count), 64'(exp_cnt));
    check("loop_instr", 64'(instr), 64'h10B);
    fetch(64'hFFFF_FFFF_FFFF_FFFC, 32'hCAFE_0001);
    check("top_pc", cur_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("top_cnt", 64'(fetch_count), 64'hF);
    advance = 1'b1;
    next_pc = 64'h0;
    tick();
    advance = 1'b0;
    check("wrap_pc", cur_pc, 64'h0);
    check("wrap_addr", imem_addr, 64'h0);
    check("wrap_req", 64'(imem_req), 64'h1);
    imem_ack = 1'b1;
    imem_data = 32'h0BAD_F00D;
    tick();
    imem_ack = 1'b0;
    check("cnt_wrap", 64'(fetch_count), 64'h0);
    check("wrap_instr", 64'(instr), 64'h0BAD_F00D);
    advance = 1'b1;
    next_pc = 64'h42;
    tick();
    advance = 1'b0;
    check("mis_pc", cur_pc, 64'h42);
    check("mis_valid", 64'(instr_valid), 64'h0);
`ifdef PC_ALIGN_CHECK_EN
    check("mis_fault", 64'(fault), 64'h1);
    check("mis_req", 64'(imem_req), 64'h0);
    imem_ack = 1'b1;
    tick();
    advance = 1'b1;
    next_pc = 64'h80;
    tick();
    imem_ack = 1'b0;
    advance = 1'b0;
    check("flt_req", 64'(imem_req), 64'h0);
    check("flt_pc", cur_pc, 64'h42);
    check("flt_cnt", 64'(fetch_count), 64'h0);
    check("flt_fault", 64'(fault), 64'h1);
`else
    check("mis_fault", 64'(fault), 64'h0);
    check("mis_req", 64'(imem_req), 64'h1);
    check("mis_addr", imem_addr, 64'h42);
    imem_ack = 1'b1;
    imem_data = 32'h4242_4242;
    tick();
    imem_ack = 1'b0;
    check("mis_cnt", 64'(fetch_count), 64'h1);
    check("mis_instr", 64'(instr), 64'h4242_4242);
    advance = 1'b1;
    next_pc = 64'h100;
    tick();
    advance = 1'b0;
    check("pre_rst_req", 64'(imem_req), 64'h1);
`endif
    #2 rst = 1'b1;
    #1;
    check("arst_req", 64'(imem_req), 64'h0);
    check("arst_pc", cur_pc, 64'h0);
    check("arst_cnt", 64'(fetch_count), 64'h0);
    check("arst_fault", 64'(fault), 64'h0);
    imem_ack = 1'b1;
    imem_data = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("late_ack_valid", 64'(instr_valid), 64'h0);
    check("late_ack_instr", 64'(instr), 64'h0);
    tick();
    check("late_ack_idle_cnt", 64'(fetch_count), 64'h0);
    check("re_req", 64'(imem_req), 64'h1);
    tick();
    imem_ack = 1'b0;
    check("re_cnt", 64'(fetch_count), 64'h1);
    check("re_instr", 64'(instr), 64'h5555_AAAA);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
